// File: rtl/cp0_mmu_regs_if.sv
// rtl/cp0_mmu_regs_if.sv - TLB command and writeback bundle between CP0 MMU registers and the TLB
interface cp0_mmu_regs_if;
    // Strobes and current register values sent to the TLB
    logic        TLBP;
    logic        TLBR;
    logic        TLBWI;
    logic        TLBWR;
    logic [31:0] EntryHi_out;
    logic [31:0] PageMask_out;
    logic [31:0] EntryLo0_out;
    logic [31:0] EntryLo1_out;
    logic [31:0] Index_out;
    logic [31:0] Random_out;
    // Results returned by the TLB for TLBR/TLBP
    logic [31:0] tlb_EntryHi_in;
    logic [31:0] tlb_PageMask_in;
    logic [31:0] tlb_EntryLo0_in;
    logic [31:0] tlb_EntryLo1_in;
    logic [31:0] tlb_Index_in;

    modport master (
        output TLBP, TLBR, TLBWI, TLBWR,
        output EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out,
        input  tlb_EntryHi_in, tlb_PageMask_in, tlb_EntryLo0_in, tlb_EntryLo1_in, tlb_Index_in
    );

    modport slave (
        input  TLBP, TLBR, TLBWI, TLBWR,
        input  EntryHi_out, PageMask_out, EntryLo0_out, EntryLo1_out, Index_out, Random_out,
        output tlb_EntryHi_in, tlb_PageMask_in, tlb_EntryLo0_in, tlb_EntryLo1_in, tlb_Index_in
    );
endinterface

// File: rtl/cp0_mmu_regs.sv
// rtl/cp0_mmu_regs.sv - MMU half of CP0: TLB-related registers, TLB strobes and fetch hazard
module cp0_mmu_regs #(
    parameter int TLB_LINE_NUM  = 32,
    parameter int LOG2_TLB_LINE = 5,
    parameter int HAZARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        mtc0_en,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    input  logic        tlbp_M,
    input  logic        tlbr_M,
    input  logic        tlbwi_M,
    input  logic        tlbwr_M,
    input  logic        tlb_exc,
    input  logic [31:0] tlb_exc_vaddr,
    output logic        tlb_hazard,
    cp0_mmu_regs_if.master tlb
);
    localparam int HW = $clog2(HAZARD_CYCLES + 1);

    localparam logic [31:0] ENTRYLO_MASK   = 32'h03FF_FFFF;
    localparam logic [31:0] PAGEMASK_MASK  = 32'h01FF_E000;
    localparam logic [31:0] ENTRYHI_MASK   = 32'hFFFF_E0FF;
    localparam logic [31:0] CONTEXT_SW     = 32'hFF80_0000;
    localparam logic [31:0] INDEX_LO_MASK  = 32'((1 << LOG2_TLB_LINE) - 1);
    localparam logic [31:0] INDEX_P_MASK   = 32'h8000_0000;

    localparam logic [LOG2_TLB_LINE-1:0] RANDOM_TOP = LOG2_TLB_LINE'(TLB_LINE_NUM - 1);

    localparam logic [4:0] R_INDEX    = 5'd0;
    localparam logic [4:0] R_RANDOM   = 5'd1;
    localparam logic [4:0] R_ENTRYLO0 = 5'd2;
    localparam logic [4:0] R_ENTRYLO1 = 5'd3;
    localparam logic [4:0] R_CONTEXT  = 5'd4;
    localparam logic [4:0] R_PAGEMASK = 5'd5;
    localparam logic [4:0] R_WIRED    = 5'd6;
    localparam logic [4:0] R_BADVADDR = 5'd8;
    localparam logic [4:0] R_ENTRYHI  = 5'd10;

    logic [31:0]              index_r;
    logic [LOG2_TLB_LINE-1:0] random_r;
    logic [LOG2_TLB_LINE-1:0] wired_r;
    logic [31:0]              entrylo0_r;
    logic [31:0]              entrylo1_r;
    logic [31:0]              context_r;
    logic [31:0]              pagemask_r;
    logic [31:0]              badvaddr_r;
    logic [31:0]              entryhi_r;
    logic [HW-1:0]            hazard_cnt;

    logic go;
    logic mtc0_go;
    logic s_tlbp, s_tlbr, s_tlbwi, s_tlbwr;
    logic hazard_trig;

    assign go      = ~stallM & ~flushM;
    assign mtc0_go = mtc0_en & go;

    // Only one TLB op may issue; TLBP > TLBR > TLBWI > TLBWR if decode ever overlaps
    assign s_tlbp  = tlbp_M & go;
    assign s_tlbr  = tlbr_M & ~tlbp_M & go;
    assign s_tlbwi = tlbwi_M & ~tlbp_M & ~tlbr_M & go;
    assign s_tlbwr = tlbwr_M & ~tlbp_M & ~tlbr_M & ~tlbwi_M & go;

    assign tlb.TLBP  = s_tlbp;
    assign tlb.TLBR  = s_tlbr;
    assign tlb.TLBWI = s_tlbwi;
    assign tlb.TLBWR = s_tlbwr;

    assign tlb.EntryHi_out  = entryhi_r;
    assign tlb.PageMask_out = pagemask_r;
    assign tlb.EntryLo0_out = entrylo0_r;
    assign tlb.EntryLo1_out = entrylo1_r;
    assign tlb.Index_out    = index_r;
    assign tlb.Random_out   = {{(32-LOG2_TLB_LINE){1'b0}}, random_r};

    // Anything that changes the TLB contents or the current ASID forces a refetch window
    assign hazard_trig = s_tlbwi | s_tlbwr | s_tlbr | (mtc0_go && mtc0_addr == R_ENTRYHI);
    assign tlb_hazard  = (hazard_cnt != '0);

    // Index: TLBP result (probe-fail flag + index) overrides a software write of the index field
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_r <= '0;
        end else if (s_tlbp) begin
            index_r <= tlb.tlb_Index_in & (INDEX_P_MASK | INDEX_LO_MASK);
        end else if (mtc0_go && mtc0_addr == R_INDEX) begin
            index_r <= (index_r & INDEX_P_MASK) | (mtc0_data & INDEX_LO_MASK);
        end
    end

    // Entry registers: exception VPN capture > TLBR readback > MTC0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entryhi_r  <= '0;
            pagemask_r <= '0;
            entrylo0_r <= '0;
            entrylo1_r <= '0;
        end else begin
            if (tlb_exc) begin
                entryhi_r <= {tlb_exc_vaddr[31:13], entryhi_r[12:0]};
            end else if (s_tlbr) begin
                entryhi_r <= tlb.tlb_EntryHi_in & ENTRYHI_MASK;
            end else if (mtc0_go && mtc0_addr == R_ENTRYHI) begin
                entryhi_r <= mtc0_data & ENTRYHI_MASK;
            end

            if (s_tlbr) begin
                pagemask_r <= tlb.tlb_PageMask_in & PAGEMASK_MASK;
                entrylo0_r <= tlb.tlb_EntryLo0_in & ENTRYLO_MASK;
                entrylo1_r <= tlb.tlb_EntryLo1_in & ENTRYLO_MASK;
            end else if (mtc0_go) begin
                if (mtc0_addr == R_PAGEMASK) pagemask_r <= mtc0_data & PAGEMASK_MASK;
                if (mtc0_addr == R_ENTRYLO0) entrylo0_r <= mtc0_data & ENTRYLO_MASK;
                if (mtc0_addr == R_ENTRYLO1) entrylo1_r <= mtc0_data & ENTRYLO_MASK;
            end
        end
    end

    // Fault capture: BadVAddr and Context.BadVPN2 on a committed TLB exception
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_r <= '0;
            context_r  <= '0;
        end else if (tlb_exc) begin
            badvaddr_r <= tlb_exc_vaddr;
            context_r  <= {context_r[31:23], tlb_exc_vaddr[31:13], 4'b0000};
        end else if (mtc0_go && mtc0_addr == R_CONTEXT) begin
            context_r  <= (context_r & ~CONTEXT_SW) | (mtc0_data & CONTEXT_SW);
        end
    end

    // Random free-runs down to Wired then wraps to the top; a Wired write restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_r <= RANDOM_TOP;
            wired_r  <= '0;
        end else if (mtc0_go && mtc0_addr == R_WIRED) begin
            wired_r  <= mtc0_data[LOG2_TLB_LINE-1:0];
            random_r <= RANDOM_TOP;
        end else if (random_r <= wired_r) begin
            random_r <= RANDOM_TOP;
        end else begin
            random_r <= random_r - LOG2_TLB_LINE'(1);
        end
    end

    // Hazard window counter; a new trigger reloads the full window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hazard_cnt <= '0;
        end else if (hazard_trig) begin
            hazard_cnt <= HW'(HAZARD_CYCLES);
        end else if (hazard_cnt != '0) begin
            hazard_cnt <= hazard_cnt - HW'(1);
        end
    end

    // MFC0 read mux; unimplemented numbers read zero
    always_comb begin
        mfc0_data = '0;
        case (mfc0_addr)
            R_INDEX:    mfc0_data = index_r;
            R_RANDOM:   mfc0_data = {{(32-LOG2_TLB_LINE){1'b0}}, random_r};
            R_ENTRYLO0: mfc0_data = entrylo0_r;
            R_ENTRYLO1: mfc0_data = entrylo1_r;
            R_CONTEXT:  mfc0_data = context_r;
            R_PAGEMASK: mfc0_data = pagemask_r;
            R_WIRED:    mfc0_data = {{(32-LOG2_TLB_LINE){1'b0}}, wired_r};
            R_BADVADDR: mfc0_data = badvaddr_r;
            R_ENTRYHI:  mfc0_data = entryhi_r;
            default:    mfc0_data = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_mmu_regs.sv
// tb/tb_cp0_mmu_regs.sv - directed self-checking bench for cp0_mmu_regs
module tb_cp0_mmu_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic        stallM, flushM;
    logic        mtc0_en;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_data;
    logic [4:0]  mfc0_addr;
    logic [31:0] mfc0_data;
    logic        tlbp_M, tlbr_M, tlbwi_M, tlbwr_M;
    logic        tlb_exc;
    logic [31:0] tlb_exc_vaddr;
    logic        tlb_hazard;

    int n_checks = 0;
    int n_errors = 0;

    cp0_mmu_regs_if tlb_bus();

    cp0_mmu_regs dut (
        .clk(clk), .rst(rst), .stallM(stallM), .flushM(flushM),
        .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
        .tlbp_M(tlbp_M), .tlbr_M(tlbr_M), .tlbwi_M(tlbwi_M), .tlbwr_M(tlbwr_M),
        .tlb_exc(tlb_exc), .tlb_exc_vaddr(tlb_exc_vaddr),
        .tlb_hazard(tlb_hazard), .tlb(tlb_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        mfc0_addr = a;
        #1;
        v = mfc0_data;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_addr = a;
        mtc0_data = d;
        mtc0_en   = 1'b1;
        tick();
        mtc0_en   = 1'b0;
    endtask

    logic [31:0] v;
    int exp_rand;

    initial begin
        rst = 1'b1; stallM = 0; flushM = 0;
        mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0; mfc0_addr = 0;
        tlbp_M = 0; tlbr_M = 0; tlbwi_M = 0; tlbwr_M = 0;
        tlb_exc = 0; tlb_exc_vaddr = 0;
        tlb_bus.tlb_EntryHi_in = 0; tlb_bus.tlb_PageMask_in = 0;
        tlb_bus.tlb_EntryLo0_in = 0; tlb_bus.tlb_EntryLo1_in = 0;
        tlb_bus.tlb_Index_in = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check("rst_hazard", {31'b0, tlb_hazard}, 0);
        check("rst_strobes", {28'b0, tlb_bus.TLBP, tlb_bus.TLBR, tlb_bus.TLBWI, tlb_bus.TLBWR}, 0);
        rd(5'd0, v);  check("rst_index", v, 0);
        rd(5'd1, v);  check("rst_random", v, 31);
        rd(5'd2, v);  check("rst_entrylo0", v, 0);
        rd(5'd4, v);  check("rst_context", v, 0);
        rd(5'd6, v);  check("rst_wired", v, 0);
        rd(5'd10, v); check("rst_entryhi", v, 0);

        // Random free-run with Wired = 0: 31 down to 0 then back to 31
        tick();
        rst = 1'b0;
        rd(5'd1, v); check("rand_start", v, 31);
        for (int k = 1; k <= 32; k++) begin
            tick();
            rd(5'd1, v);
            check("rand_run", v, (k == 32) ? 32'd31 : 32'(31 - k));
            check("rand_hazard", {31'b0, tlb_hazard}, 0);
        end

        // Wired = 8: reload to 31 on the write edge, count to 8, wrap to 31
        mtc0(5'd6, 32'd8);
        rd(5'd6, v); check("wired_rd", v, 8);
        rd(5'd1, v); check("wired_rand0", v, 31);
        exp_rand = 31;
        for (int k = 0; k < 30; k++) begin
            tick();
            exp_rand = (exp_rand == 8) ? 31 : exp_rand - 1;
            rd(5'd1, v);
            check("wired_rand", v, 32'(exp_rand));
        end

        // EntryHi write masking, no same-cycle bypass, 2-cycle hazard
        mtc0_addr = 5'd10; mtc0_data = 32'hFFFF_FFFF; mtc0_en = 1'b1;
        rd(5'd10, v); check("mfc0_no_bypass", v, 0);
        check("ehi_haz_pre", {31'b0, tlb_hazard}, 0);
        tick();
        mtc0_en = 1'b0;
        check("ehi_haz_1", {31'b0, tlb_hazard}, 1);
        rd(5'd10, v); check("ehi_mask", v, 32'hFFFF_E0FF);
        tick(); check("ehi_haz_2", {31'b0, tlb_hazard}, 1);
        tick(); check("ehi_haz_3", {31'b0, tlb_hazard}, 0);

        // Flushed MTC0 is suppressed; other writable masks
        flushM = 1'b1;
        mtc0(5'd3, 32'hFFFF_FFFF);
        flushM = 1'b0;
        rd(5'd3, v); check("flush_mtc0", v, 0);
        mtc0(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, v); check("elo1_mask", v, 32'h03FF_FFFF);
        mtc0(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, v); check("pmask_mask", v, 32'h01FF_E000);
        mtc0(5'd4, 32'hFFFF_FFFF);
        rd(5'd4, v); check("ctx_mask", v, 32'hFF80_0000);
        mtc0(5'd7, 32'hFFFF_FFFF);
        rd(5'd7, v); check("unimpl_rd", v, 0);

        // TLBP issue and capture
        tlbp_M = 1'b1; tlb_bus.tlb_Index_in = 32'h8000_0000;
        #1;
        check("tlbp_strobe", {31'b0, tlb_bus.TLBP}, 1);
        tick();
        tlbp_M = 1'b0;
        #1;
        check("tlbp_strobe_off", {31'b0, tlb_bus.TLBP}, 0);
        rd(5'd0, v); check("tlbp_index", v, 32'h8000_0000);
        check("tlbp_no_hazard", {31'b0, tlb_hazard}, 0);

        // TLBP while stalled: no strobe, Index unchanged
        stallM = 1'b1; tlbp_M = 1'b1; tlb_bus.tlb_Index_in = 32'h0000_0005;
        #1;
        check("tlbp_stall_strobe", {31'b0, tlb_bus.TLBP}, 0);
        tick();
        stallM = 1'b0; tlbp_M = 1'b0;
        rd(5'd0, v); check("tlbp_stall_index", v, 32'h8000_0000);

        // TLBR (with TLBWI also decoded: TLBR wins), outputs show pre-edge values
        tlb_bus.tlb_EntryHi_in  = 32'h1234_5FFF;
        tlb_bus.tlb_PageMask_in = 32'hFFFF_FFFF;
        tlb_bus.tlb_EntryLo0_in = 32'hFFFF_FFFF;
        tlb_bus.tlb_EntryLo1_in = 32'h0000_0000;
        tlbr_M = 1'b1; tlbwi_M = 1'b1;
        #1;
        check("tlbr_strobe", {31'b0, tlb_bus.TLBR}, 1);
        check("tlbr_prio_wi", {31'b0, tlb_bus.TLBWI}, 0);
        check("out_entryhi", tlb_bus.EntryHi_out, 32'hFFFF_E0FF);
        check("out_elo1", tlb_bus.EntryLo1_out, 32'h03FF_FFFF);
        check("out_index", tlb_bus.Index_out, 32'h8000_0000);
        tick();
        tlbr_M = 1'b0; tlbwi_M = 1'b0;
        check("tlbr_haz_1", {31'b0, tlb_hazard}, 1);
        rd(5'd2, v);  check("tlbr_elo0", v, 32'h03FF_FFFF);
        rd(5'd3, v);  check("tlbr_elo1", v, 0);
        rd(5'd5, v);  check("tlbr_pmask", v, 32'h01FF_E000);
        rd(5'd10, v); check("tlbr_ehi", v, 32'h1234_40FF);
        tick(); check("tlbr_haz_2", {31'b0, tlb_hazard}, 1);
        tick(); check("tlbr_haz_3", {31'b0, tlb_hazard}, 0);

        // TLBWR strobe and hazard
        tlbwr_M = 1'b1;
        #1;
        check("tlbwr_strobe", {31'b0, tlb_bus.TLBWR}, 1);
        tick();
        tlbwr_M = 1'b0;
        check("tlbwr_haz", {31'b0, tlb_hazard}, 1);
        repeat (2) tick();

        // TLB exception capture, ASID 0x2A preserved, no hazard
        mtc0(5'd10, 32'h0000_002A);
        repeat (3) tick();
        tlb_exc = 1'b1; tlb_exc_vaddr = 32'h1234_5678;
        tick();
        tlb_exc = 1'b0;
        check("exc_no_hazard", {31'b0, tlb_hazard}, 0);
        rd(5'd8, v);  check("exc_badvaddr", v, 32'h1234_5678);
        rd(5'd10, v); check("exc_entryhi", v, 32'h1234_402A);
        rd(5'd4, v);  check("exc_context", v, 32'hFF89_1A20);
        check("exc_badvpn2", (v >> 4) & 32'h0007_FFFF, 32'h0009_1A2);

        // Exception and MTC0 EntryHi on the same edge: exception wins
        tlb_exc = 1'b1; tlb_exc_vaddr = 32'hABCD_E000;
        mtc0_addr = 5'd10; mtc0_data = 32'h0000_0055; mtc0_en = 1'b1;
        tick();
        tlb_exc = 1'b0; mtc0_en = 1'b0;
        rd(5'd10, v); check("exc_vs_mtc0", v, 32'hABCD_E02A);
        rd(5'd4, v);  check("exc2_context", v, 32'hFFD5_E6F0);
        repeat (3) tick();

        // Asynchronous reset in the middle of a hazard window
        tlbwi_M = 1'b1;
        tick();
        tlbwi_M = 1'b0;
        check("pre_arst_haz", {31'b0, tlb_hazard}, 1);
        rst = 1'b1;
        #1;
        check("arst_hazard", {31'b0, tlb_hazard}, 0);
        rd(5'd10, v); check("arst_entryhi", v, 0);
        rd(5'd1, v);  check("arst_random", v, 31);
        rd(5'd0, v);  check("arst_index", v, 0);
        rd(5'd8, v);  check("arst_badvaddr", v, 0);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
